// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe write-burst path: FSM encoding and frame geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pcie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } burst_state_t;

  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned DEF_FIFO_AW     = 6;
  localparam int unsigned DEF_BURST_LEN   = 32;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
  localparam logic [31:0] DEF_FRAME_BYTES = 32'd4147200;
  localparam int unsigned DEF_FLUSH_TO    = 16;

endpackage

// File: rtl/pcie_sync_fifo.sv
// Synchronous 32-bit first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible at rd_dat the cycle after the push.
// Backpressure: pushes while full are ignored unless a pop happens in the same cycle.
module pcie_sync_fifo #(
  parameter int unsigned AW = 6
) (
  input  logic          pclk_div2,
  input  logic          core_rst,
  input  logic          wr_en,
  input  logic [31:0]   wr_dat,
  input  logic          rd_en,
  output logic [31:0]   rd_dat,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH);
  assign pop    = rd_en && !empty;
  assign push   = wr_en && (!full || pop);
  assign rd_dat = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge pclk_div2) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge pclk_div2) begin
    if (core_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pcie_wr_burst_buf.sv
// Buffers packed 32-bit words and cuts them into addressed PCIe DMA write bursts.
// Latency: req_valid rises 2 cycles after the cycle presenting the word that fills a burst.
// Backpressure: none on input (drops + sticky overflow when full); req/dout use valid/ready.
module pcie_wr_burst_buf
  import pcie_pkg::*;
#(
  parameter int unsigned FIFO_AW     = DEF_FIFO_AW,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [31:0] FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int unsigned FLUSH_TO    = DEF_FLUSH_TO
) (
  input  logic        pclk_div2,
  input  logic        core_rst,
  input  logic        wr_en_32_in,
  input  logic [31:0] wr_data_32_in,
  input  logic        frame_sync,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic [7:0]  req_len,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [31:0] dout_data,
  output logic        dout_last,
  output logic        frame_done,
  output logic        overflow
);

  if (BURST_LEN < 1 || BURST_LEN > 255 || BURST_LEN > 2**FIFO_AW ||
      (FRAME_BYTES / BYTES_PER_WORD) % BURST_LEN != 0) begin : g_bad_burst_len
    $error("pcie_wr_burst_buf: illegal BURST_LEN for this FIFO depth / frame size");
  end

  localparam int unsigned        IW         = $clog2(FLUSH_TO + 1);
  localparam logic [IW-1:0]      IDLE_MAX   = IW'(FLUSH_TO);
  localparam logic [FIFO_AW:0]   BURST_CNT  = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [7:0]         BURST_LEN8 = 8'(BURST_LEN);
  localparam logic [31:0]        FRAME_END  = BASE_ADDR + FRAME_BYTES;

  burst_state_t     state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       beat_q;
  logic [31:0]      addr_q;
  logic [IW-1:0]    idle_q;
  logic             sync_pend_q;
  logic             frame_done_q;
  logic             overflow_q;
  logic [31:0]      fifo_dat;
  logic [FIFO_AW:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             req_hs;
  logic             beat_hs;
  logic             burst_end;
  logic             sync_hit;
  logic             wrap;
  logic [31:0]      nxt_addr;

  pcie_sync_fifo #(.AW(FIFO_AW)) u_fifo (
    .pclk_div2 (pclk_div2),
    .core_rst  (core_rst),
    .wr_en     (wr_en_32_in),
    .wr_dat    (wr_data_32_in),
    .rd_en     (beat_hs),
    .rd_dat    (fifo_dat),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign req_valid  = (state_q == ST_REQ);
  assign req_addr   = req_valid ? addr_q : '0;
  assign req_len    = req_valid ? len_q : '0;
  assign dout_valid = (state_q == ST_DATA) && !fifo_empty;
  assign dout_data  = dout_valid ? fifo_dat : '0;
  assign dout_last  = dout_valid && (beat_q == 8'd1);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  assign req_hs    = req_valid && req_ready;
  assign beat_hs   = dout_valid && dout_ready;
  assign burst_end = beat_hs && (beat_q == 8'd1);
  assign nxt_addr  = addr_q + 32'(len_q) * BYTES_PER_WORD;
  assign wrap      = (nxt_addr >= FRAME_END);
  assign sync_hit  = sync_pend_q || frame_sync;

  // Next-state: full bursts take precedence over an idle-timeout partial flush.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_cnt >= BURST_CNT) begin
          state_d = ST_REQ;
          len_d   = BURST_LEN8;
        end else if (idle_q == IDLE_MAX && !fifo_empty) begin
          state_d = ST_REQ;
          len_d   = 8'(fifo_cnt);
        end
      end
      ST_REQ:  if (req_ready) state_d = ST_DATA;
      ST_DATA: if (burst_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched length and remaining-beat counter.
  always_ff @(posedge pclk_div2) begin
    if (core_rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      if (req_hs)       beat_q <= len_q;
      else if (beat_hs) beat_q <= beat_q - 8'd1;
    end
  end

  // Address pointer: advance or wrap at burst end; a pending frame_sync overrides both.
  always_ff @(posedge pclk_div2) begin
    if (core_rst) begin
      addr_q       <= BASE_ADDR;
      sync_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= burst_end && wrap && !sync_hit;
      if (burst_end) begin
        if (sync_hit) begin
          addr_q      <= BASE_ADDR;
          sync_pend_q <= 1'b0;
        end else if (wrap) begin
          addr_q <= BASE_ADDR;
        end else begin
          addr_q <= nxt_addr;
        end
      end else if (sync_hit && state_q == ST_IDLE && fifo_empty) begin
        addr_q      <= BASE_ADDR;
        sync_pend_q <= 1'b0;
      end else if (frame_sync) begin
        sync_pend_q <= 1'b1;
      end
    end
  end

  // Input idle timer (saturating) and sticky drop flag.
  always_ff @(posedge pclk_div2) begin
    if (core_rst) begin
      idle_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_32_in)             idle_q <= '0;
      else if (idle_q != IDLE_MAX) idle_q <= idle_q + 1'b1;
      if (wr_en_32_in && fifo_full && !beat_hs) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_wr_burst_buf.sv
// Directed bench for pcie_wr_burst_buf with a 256-byte frame so address wraps are reachable.
// Latency: n/a.
// Backpressure: the bench drives req_ready/dout_ready per step.
module tb_pcie_wr_burst_buf;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        fsync;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic        dout_last;
  logic        frame_done;
  logic        overflow;

  int vectors = 0;
  int errors  = 0;
  int waits;

  pcie_wr_burst_buf #(.FRAME_BYTES(32'd256)) dut (
    .pclk_div2     (clk),
    .core_rst      (rst),
    .wr_en_32_in   (wr_en),
    .wr_data_32_in (wr_data),
    .frame_sync    (fsync),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_data     (dout_data),
    .dout_last     (dout_last),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 32'(i);
      step();
    end
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req_valid"},  32'(req_valid),  32'd0);
    chk({tag, " req_addr"},   req_addr,        32'd0);
    chk({tag, " req_len"},    32'(req_len),    32'd0);
    chk({tag, " dout_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, " dout_data"},  dout_data,       32'd0);
    chk({tag, " dout_last"},  32'(dout_last),  32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, " overflow"},   32'(overflow),   32'd0);
  endtask

  // Expects one request then elen beats of consecutive data; req_ready/dout_ready must be 1.
  task automatic expect_burst(input string tag, input logic [31:0] eaddr, input int elen,
                              input logic [31:0] ed0, input logic efd, output int nwait);
    nwait = 0;
    while (req_valid !== 1'b1 && nwait < 400) begin
      step();
      nwait++;
    end
    chk({tag, " req_valid"}, 32'(req_valid), 32'd1);
    chk({tag, " req_addr"},  req_addr,       eaddr);
    chk({tag, " req_len"},   32'(req_len),   32'(elen));
    step();
    for (int i = 0; i < elen; i++) begin
      int w = 0;
      while (dout_valid !== 1'b1 && w < 400) begin
        step();
        w++;
      end
      chk({tag, " dout_data"}, dout_data,      ed0 + 32'(i));
      chk({tag, " dout_last"}, 32'(dout_last), 32'(i == elen - 1));
      step();
    end
    chk({tag, " frame_done"}, 32'(frame_done), 32'(efd));
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    fsync      = 1'b0;
    req_ready  = 1'b0;
    dout_ready = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // 64 back-to-back words with ready held high: two full bursts, second one wraps the frame.
    req_ready  = 1'b1;
    dout_ready = 1'b1;
    fork
      push_words(64, 32'h0000_1000);
      begin
        expect_burst("A1", 32'h0, 32, 32'h0000_1000, 1'b0, waits);
        chk("A1 req latency", 32'(waits), 32'd33);
        expect_burst("A2", 32'h80, 32, 32'h0000_1020, 1'b1, waits);
      end
    join

    // 5 words then idle: partial flush after the timeout, then the pointer sits at 0x14.
    push_words(5, 32'h0000_2000);
    expect_burst("B1", 32'h0, 5, 32'h0000_2000, 1'b0, waits);
    chk("B1 flush delay", 32'(waits), 32'd17);
    fork
      push_words(32, 32'h0000_3000);
      expect_burst("B2", 32'h14, 32, 32'h0000_3000, 1'b0, waits);
    join

    // Stall the DMA while pushing 70 words: word 65 is the first drop.
    req_ready  = 1'b0;
    dout_ready = 1'b0;
    push_words(64, 32'h0000_4000);
    chk("C ovf after 64", 32'(overflow), 32'd0);
    push_words(1, 32'h0000_4040);
    chk("C ovf after 65", 32'(overflow), 32'd1);
    push_words(5, 32'h0000_4041);
    req_ready  = 1'b1;
    dout_ready = 1'b1;
    expect_burst("C1", 32'h94, 32, 32'h0000_4000, 1'b1, waits);
    expect_burst("C2", 32'h0, 32, 32'h0000_4020, 1'b0, waits);
    chk("C ovf sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    step();
    chk_all_zero("C reset");
    rst = 1'b0;
    step();

    // 128 words into a 256-byte frame: addresses 0,0x80,0,0x80 with frame_done on every 2nd.
    fork
      push_words(128, 32'h0000_5000);
      begin
        expect_burst("D1", 32'h0,  32, 32'h0000_5000, 1'b0, waits);
        expect_burst("D2", 32'h80, 32, 32'h0000_5020, 1'b1, waits);
        expect_burst("D3", 32'h0,  32, 32'h0000_5040, 1'b0, waits);
        expect_burst("D4", 32'h80, 32, 32'h0000_5060, 1'b1, waits);
      end
    join

    // frame_sync during DATA: burst keeps its address, next burst restarts at BASE_ADDR.
    req_ready = 1'b0;
    push_words(32, 32'h0000_6000);
    req_ready = 1'b1;
    fork
      expect_burst("E1", 32'h0, 32, 32'h0000_6000, 1'b0, waits);
      begin
        int w = 0;
        while (dout_valid !== 1'b1 && w < 400) begin
          step();
          w++;
        end
        repeat (3) step();
        fsync = 1'b1;
        step();
        fsync = 1'b0;
      end
    join
    push_words(5, 32'h0000_6100);
    expect_burst("E2", 32'h0, 5, 32'h0000_6100, 1'b0, waits);
    push_words(5, 32'h0000_6200);
    expect_burst("E3", 32'h14, 5, 32'h0000_6200, 1'b0, waits);

    // Reset in the middle of DATA abandons the burst and empties the FIFO.
    dout_ready = 1'b0;
    push_words(32, 32'h0000_7000);
    waits = 0;
    while (dout_valid !== 1'b1 && waits < 400) begin
      step();
      waits++;
    end
    chk("F in DATA", 32'(dout_valid), 32'd1);
    rst = 1'b1;
    step();
    chk_all_zero("F reset");
    rst        = 1'b0;
    dout_ready = 1'b1;
    step();
    push_words(5, 32'h0000_7100);
    expect_burst("F1", 32'h0, 5, 32'h0000_7100, 1'b0, waits);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
